fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_hold_buf.sv | 50 +++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants and types for the instruction-fetch slice:
//                default PC / instruction widths, the canonical NOP
//                (addi x0,x0,0) and the fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int PC_SIZE      = 64;
  localparam int INS_MEM_SIZE = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request outstanding on the bus (or about to be)
    ST_WAIT = 2'd1,  // accepted, waiting for the response
    ST_DROP = 2'd2   // accepted before a redirect; response must be discarded
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_hold_buf
//  Description : One-entry skid buffer that catches a fetch response arriving
//                while IF/ID is occupied and stalled.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                clear           - empty the entry (highest priority)
//                wr_en/wr_pc/wr_instr - capture a response (beats rd_en)
//                rd_en           - entry consumed this cycle
//                valid/pc/instr  - current entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buf
  import riscv_pkg::*;
#(
  parameter int PC_W    = PC_SIZE,
  parameter int INSTR_W = INS_MEM_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [PC_W-1:0]    wr_pc,
  input  logic [INSTR_W-1:0] wr_instr,
  input  logic               rd_en,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= INSTR_W'(NOP);
    end else if (clear) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      // A read in the same cycle is a pass-through: the old entry leaves,
      // the new one takes its place.
      valid <= 1'b1;
      pc    <= wr_pc;
      instr <= wr_instr;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues one instruction-memory request
//                at a time, fills the IF/ID pipeline register, absorbs stalls
//                with a one-entry hold buffer and handles redirects from the
//                memory stage (discarding a response already in flight).
//  Ports       : i_clk, i_rst (async, active-low)
//                i_stall                          - hold IF/ID
//                i_redirect_valid/i_redirect_pc   - taken branch / jump
//                o_imem_req/o_imem_addr/i_imem_ready  - request channel
//                i_imem_rvalid/i_imem_rdata       - response channel
//                o_if_id_valid/o_if_id_reg        - IF/ID register {pc, instr}
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                        PC_SIZE      = riscv_pkg::PC_SIZE,
  parameter int                        INS_MEM_SIZE = riscv_pkg::INS_MEM_SIZE,
  parameter logic [PC_SIZE-1:0]        RESET_PC     = '0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_stall,
  input  logic                              i_redirect_valid,
  input  logic [PC_SIZE-1:0]                i_redirect_pc,
  output logic                              o_imem_req,
  output logic [PC_SIZE-1:0]                o_imem_addr,
  input  logic                              i_imem_ready,
  input  logic                              i_imem_rvalid,
  input  logic [INS_MEM_SIZE-1:0]           i_imem_rdata,
  output logic                              o_if_id_valid,
  output logic [PC_SIZE+INS_MEM_SIZE-1:0]   o_if_id_reg
);

  fetch_state_t              state, state_nxt;
  logic [PC_SIZE-1:0]        pc, pc_nxt;
  logic [PC_SIZE-1:0]        fetch_pc, fetch_pc_nxt;
  logic [PC_SIZE-1:0]        redirect_aligned;
  logic                      accept;
  logic                      deliver;
  logic                      drain;
  logic                      buf_wr;
  logic                      buf_valid, buf_valid_nxt;
  logic [PC_SIZE-1:0]        buf_pc;
  logic [INS_MEM_SIZE-1:0]   buf_instr;

  assign redirect_aligned = i_redirect_pc & ~PC_SIZE'(3);

  fetch_hold_buf #(
    .PC_W    (PC_SIZE),
    .INSTR_W (INS_MEM_SIZE)
  ) u_hold_buf (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .clear    (i_redirect_valid),
    .wr_en    (buf_wr),
    .wr_pc    (fetch_pc),
    .wr_instr (i_imem_rdata),
    .rd_en    (drain),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  always_comb begin
    // o_imem_req is only ever high in ST_REQ, so accept implies ST_REQ.
    accept  = o_imem_req && i_imem_ready;
    deliver = (state == ST_WAIT) && i_imem_rvalid && !i_redirect_valid;
    // A buffered entry always goes into IF/ID ahead of a fresh response.
    drain   = buf_valid && !i_stall && !i_redirect_valid;
    buf_wr  = deliver && (drain || (o_if_id_valid && i_stall));

    if (i_redirect_valid) begin
      buf_valid_nxt = 1'b0;
    end else if (buf_wr) begin
      buf_valid_nxt = 1'b1;
    end else if (drain) begin
      buf_valid_nxt = 1'b0;
    end else begin
      buf_valid_nxt = buf_valid;
    end

    state_nxt    = state;
    pc_nxt       = pc;
    fetch_pc_nxt = fetch_pc;
    case (state)
      ST_REQ: begin
        if (accept) begin
          fetch_pc_nxt = pc;
          pc_nxt       = pc + PC_SIZE'(4);
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: if (i_imem_rvalid) state_nxt = ST_REQ;
      ST_DROP: if (i_imem_rvalid) state_nxt = ST_REQ;
      default: state_nxt = ST_REQ;
    endcase

    if (i_redirect_valid) begin
      pc_nxt = redirect_aligned;
      // A request accepted now, or one still awaiting its response, leaves a
      // stale response on the bus. If that response lands in this very cycle
      // it is simply discarded and fetching restarts straight away.
      if ((state == ST_REQ && accept) || (state == ST_WAIT && !i_imem_rvalid)) begin
        state_nxt = ST_DROP;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_REQ;
      pc            <= RESET_PC;
      fetch_pc      <= RESET_PC;
      o_imem_req    <= 1'b0;
      o_imem_addr   <= RESET_PC;
      o_if_id_valid <= 1'b0;
      o_if_id_reg   <= {RESET_PC, INS_MEM_SIZE'(NOP)};
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_pc    <= fetch_pc_nxt;
      // Throttle requests while the hold buffer is occupied so that a
      // response always has somewhere to go.
      o_imem_req  <= (state_nxt == ST_REQ) && !buf_valid_nxt;
      o_imem_addr <= pc_nxt;

      if (i_redirect_valid) begin
        o_if_id_valid                   <= 1'b0;
        o_if_id_reg[INS_MEM_SIZE-1:0]   <= INS_MEM_SIZE'(NOP);
      end else if (drain) begin
        o_if_id_valid <= 1'b1;
        o_if_id_reg   <= {buf_pc, buf_instr};
      end else if (deliver && !buf_wr) begin
        o_if_id_valid <= 1'b1;
        o_if_id_reg   <= {fetch_pc, i_imem_rdata};
      end else if (!i_stall) begin
        // Bubble: fields keep their last value, only valid drops.
        o_if_id_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
